// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the Wishbone load/store master.
//   - default address/data widths
//   - FSM state enum (IDLE/BUS/RESP), also exposed for debug
//   - request struct {we, adr, dat, sel}
package wb_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = WB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic                 we;
        logic [WB_ADDR_W-1:0] adr;
        logic [WB_DATA_W-1:0] dat;
        logic [WB_SEL_W-1:0]  sel;
    } wb_req_t;

endpackage

// File: rtl/wb_lsu_master_if.sv
// wb_lsu_master_if: core request/response channels plus Wishbone classic bus.
//   master modport: the LSU side (accepts requests, drives the bus).
//   slave modport : the environment side (core + Wishbone responder).
// Handshake rule for both req_* and rsp_*: a transfer happens on a rising edge
// where valid and ready are both 1; the producer holds valid and payload
// stable until that edge, and ready never depends combinationally on valid.
interface wb_lsu_master_if #(
    parameter int ADDR_W = wb_pkg::WB_ADDR_W,
    parameter int DATA_W = wb_pkg::WB_DATA_W
);
    localparam int SEL_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [SEL_W-1:0]  req_sel;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [ADDR_W-1:0] wb_adr_o;
    logic [DATA_W-1:0] wb_dat_o;
    logic [SEL_W-1:0]  wb_sel_o;
    logic [DATA_W-1:0] wb_dat_i;
    logic              wb_ack_i;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_sel,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_sel,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_dat_i, wb_ack_i
    );

endinterface

// File: rtl/wb_lsu_wdt.sv
// wb_lsu_wdt: bus-cycle watchdog for the load/store master.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart the count (transaction accepted)
//   en         : one more bus cycle passed without ack
//   expire     : this enabled cycle is the LIMIT-th without ack
// Only instantiated when WB_LSU_TIMEOUT_EN is defined.
module wb_lsu_wdt #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    // count holds the number of ack-less cycles already seen, so the
    // current cycle is the LIMIT-th one when count == LIMIT-1.
    assign expire = en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/wb_lsu_master.sv
// wb_lsu_master: Wishbone classic initiator for single load/store requests.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : wb_lsu_master_if.master (req_*, rsp_*, wb_* signals)
//   dbg_state  : current FSM state, for checkers and debug
// One transaction in flight: IDLE -> BUS -> RESP -> IDLE, all outputs registered.
// Optional feature macro: WB_LSU_TIMEOUT_EN (abort a bus cycle with rsp_err
// after TIMEOUT_CYCLES cycles without ack). Undefined: wait for ack forever.
module wb_lsu_master
    import wb_pkg::*;
#(
    parameter int ADDR_W         = WB_ADDR_W,
    parameter int DATA_W         = WB_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wb_lsu_master_if.master       bus,
    output wb_state_e             dbg_state
);
    localparam int SEL_W = DATA_W / 8;

    wb_state_e         state;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              cyc_q;
    logic              we_q;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] dat_q;
    logic [SEL_W-1:0]  sel_q;

`ifdef WB_LSU_TIMEOUT_EN
    logic wdt_clr;
    logic wdt_en;
    logic wdt_expire;

    // Count restarts on acceptance, so it is zero on the first BUS cycle.
    assign wdt_clr = (state == IDLE) && bus.req_valid;
    assign wdt_en  = (state == BUS) && !bus.wb_ack_i;

    wb_lsu_wdt #(.LIMIT(TIMEOUT_CYCLES)) u_wdt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wdt_clr),
        .en     (wdt_en),
        .expire (wdt_expire)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // req_ready is 1 throughout IDLE, so req_valid alone is the accept.
                    if (bus.req_valid) begin
                        req_ready_q <= 1'b0;
                        cyc_q       <= 1'b1;
                        we_q        <= bus.req_we;
                        adr_q       <= bus.req_addr;
                        dat_q       <= bus.req_wdata;
                        sel_q       <= bus.req_sel;
                        state       <= BUS;
                    end
                end
                BUS: begin
                    // Ack takes priority over an expiring watchdog in the same cycle.
                    if (bus.wb_ack_i) begin
                        cyc_q       <= 1'b0;
                        we_q        <= 1'b0;
                        rdata_q     <= we_q ? '0 : bus.wb_dat_i;
                        err_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end
`ifdef WB_LSU_TIMEOUT_EN
                    else if (wdt_expire) begin
                        cyc_q       <= 1'b0;
                        we_q        <= 1'b0;
                        rdata_q     <= '0;
                        err_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end
`endif
                end
                RESP: begin
                    // Ready returns one cycle after the handshake: no back-to-back accept.
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    cyc_q       <= 1'b0;
                    we_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.wb_cyc_o  = cyc_q;
    assign bus.wb_stb_o  = cyc_q;
    assign bus.wb_we_o   = we_q;
    assign bus.wb_adr_o  = adr_q;
    assign bus.wb_dat_o  = dat_q;
    assign bus.wb_sel_o  = sel_q;
    assign dbg_state     = state;

endmodule
